sweep_ctrl_8bit: RTL and testbench
==================================

Name: sweep_ctrl_8bit

Overview:
- Sequencer that drives the pause/mode controls of an external 8-bit up/down counter.
- Runs triangle sweeps between programmable bounds lo and hi, holding the counter at each turn-around point for a programmable dwell.
- Counts completed sweeps. Stops after N sweeps, or runs continuously until aborted.
- Sits beside the counter and shares clk/rst_n with it. It observes the counter value and owns the counter's pause and mode inputs.

Parameters:
- DWELL_W, 4: width of the dwell input (dwell 0..2^DWELL_W-1 cycles).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; latches config and starts a run when IDLE.
- abort  in  1  stops the run; state returns to IDLE next cycle.
- lo  in  8  lower bound (unsigned).
- hi  in  8  upper bound (unsigned).
- dwell  in  DWELL_W  extra hold cycles at each bound.
- n_sweeps  in  8  sweeps to run; 0 = continuous.
- cnt_value  in  8  current counter output.
- cnt_pause  out  1  to the counter pause input; 1 = hold.
- cnt_mode  out  1  to the counter mode input; 1 = count down, 0 = count up.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a finite run completes.
- err  out  1  one-cycle pulse when start is rejected because lo > hi.
- sweep_cnt  out  8  completed sweeps in the current or most recent run.

Behaviour:
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, err = 0, sweep_cnt = 0.
  - cnt_pause = 1, cnt_mode = 0.
  - The counter shares rst_n, so it also reads 0 after reset.
- States: IDLE, SEEK, UP, DWELL_HI, DOWN, DWELL_LO, DONE.
- Config latch:
  - lo, hi, dwell and n_sweeps are registered on an accepted start.
  - Later input changes have no effect until the next accepted start.
- cnt_pause and cnt_mode are combinational (Mealy) from state, latched config and cnt_value, so the counter stops exactly on a bound.
- IDLE:
  - Outputs: pause = 1, mode = 0.
  - start & !abort & lo <= hi: sweep_cnt <= 0, go to SEEK.
  - start & lo > hi: err = 1 for 1 cycle, stay in IDLE.
  - start & abort in the same cycle: abort wins; start is ignored and no err is raised.
- SEEK (move the counter to lo):
  - cnt_value < lo: pause = 0, mode = 0.
  - cnt_value > lo: pause = 0, mode = 1.
  - cnt_value == lo: pause = 1, go to UP.
  - Equality compare only; the counter never wraps.
- UP:
  - cnt_value != hi: pause = 0, mode = 0.
  - cnt_value == hi: pause = 1; go to DWELL_HI if dwell != 0, else go to DOWN.
- DWELL_HI:
  - pause = 1 for exactly dwell cycles, then go to DOWN.
  - The counter holds at hi for dwell+1 cycles in total.
- DOWN:
  - cnt_value != lo: pause = 0, mode = 1.
  - cnt_value == lo: pause = 1, then:
    - dwell != 0: go to DWELL_LO.
    - dwell == 0: end of sweep (see below).
- DWELL_LO:
  - pause = 1 for exactly dwell cycles, then end of sweep.
- End of sweep:
  - sweep_cnt increments, saturating at 255.
  - If n_sweeps != 0 and the new sweep_cnt == n_sweeps: go to DONE. Otherwise go to UP.
- DONE:
  - pause = 1, done = 1 for this single cycle, then go to IDLE.
  - sweep_cnt holds its final value until the next accepted start.
- lo == hi:
  - UP sees hi immediately; each sweep is two hold phases and the counter never moves.
  - A sweep takes 2*(dwell+1) cycles.
- abort in any non-IDLE state:
  - cnt_pause = 1 combinationally in the abort cycle, so the counter does not step.
  - Next state is IDLE. No done pulse. sweep_cnt retains its value.
- start while busy is ignored.
- rst_n asserted mid-run: state goes to IDLE immediately and all outputs take their reset values.

Test Plan:
- Reset, then start with lo = 3, hi = 5, dwell = 2, n_sweeps = 1:
  - Counter sequence is 0,1,2,3,3,4,5,5,5,5,4,3,3,3.
  - Then a DONE cycle with done = 1 and sweep_cnt = 1, then busy = 0, with the counter holding at 3 throughout.
- Counter at 10, start with lo = 4, hi = 6, dwell = 0, n_sweeps = 2:
  - SEEK counts down 10 → 4.
  - Then two sweeps 4,5,6,6,5,4, with 1-cycle holds at the bounds.
  - done pulse, sweep_cnt = 2, final value 4.
- n_sweeps = 0, lo = 0, hi = 2, dwell = 1:
  - Runs continuously; sweep_cnt reaches 5.
  - Assert abort while in UP with value 1: counter stays at 1 and busy = 0 next cycle, no done, sweep_cnt = 5.
- start with lo = 9, hi = 8:
  - err = 1 for 1 cycle, stays in IDLE, cnt_pause = 1, counter unchanged.
- start and abort in the same IDLE cycle: stays in IDLE, no err.
- start while busy: ignored, and a changed lo/hi does not alter the run in progress.
- rst_n pulsed low mid-DOWN:
  - Immediately: busy = 0, sweep_cnt = 0, counter = 0.
  - A subsequent start with lo = 1, hi = 1, dwell = 0, n_sweeps = 1 gives counter 0 → 1, a hold, then a done pulse.

Source files
------------

// File: rtl/sweep_ctrl_8bit.sv
// Triangle-sweep sequencer for an external 8-bit up/down counter: seeks to lo, sweeps lo<->hi
// with a programmable dwell at each bound, and counts completed sweeps.
module sweep_ctrl_8bit #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         lo,
    input  logic [7:0]         hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         n_sweeps,
    input  logic [7:0]         cnt_value,
    output logic               cnt_pause,
    output logic               cnt_mode,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         sweep_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StSeek,
        StUp,
        StDwellHi,
        StDown,
        StDwellLo,
        StDone
    } state_e;

    localparam logic [DWELL_W-1:0] DwellOne = 1;

    state_e             state_q;
    logic [7:0]         lo_q;
    logic [7:0]         hi_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         n_sweeps_q;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic [7:0]         sweep_cnt_q;
    logic               err_q;

    logic [7:0] sweep_inc;
    logic       last_sweep;
    logic       aborting;

    assign sweep_inc  = (sweep_cnt_q == 8'hFF) ? 8'hFF : sweep_cnt_q + 8'd1;
    assign last_sweep = (n_sweeps_q != 8'd0) && (sweep_inc == n_sweeps_q);
    assign aborting   = abort && (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            n_sweeps_q  <= '0;
            dwell_cnt_q <= '0;
            sweep_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (aborting) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            if (lo > hi) begin
                                err_q <= 1'b1;
                            end else begin
                                lo_q        <= lo;
                                hi_q        <= hi;
                                dwell_q     <= dwell;
                                n_sweeps_q  <= n_sweeps;
                                sweep_cnt_q <= '0;
                                state_q     <= StSeek;
                            end
                        end
                    end
                    StSeek: begin
                        if (cnt_value == lo_q) state_q <= StUp;
                    end
                    StUp: begin
                        if (cnt_value == hi_q) begin
                            if (dwell_q != '0) begin
                                dwell_cnt_q <= dwell_q - DwellOne;
                                state_q     <= StDwellHi;
                            end else begin
                                state_q <= StDown;
                            end
                        end
                    end
                    StDwellHi: begin
                        if (dwell_cnt_q == '0) state_q <= StDown;
                        else dwell_cnt_q <= dwell_cnt_q - DwellOne;
                    end
                    StDown: begin
                        if (cnt_value == lo_q) begin
                            if (dwell_q != '0) begin
                                dwell_cnt_q <= dwell_q - DwellOne;
                                state_q     <= StDwellLo;
                            end else begin
                                sweep_cnt_q <= sweep_inc;
                                state_q     <= last_sweep ? StDone : StUp;
                            end
                        end
                    end
                    StDwellLo: begin
                        if (dwell_cnt_q == '0) begin
                            sweep_cnt_q <= sweep_inc;
                            state_q     <= last_sweep ? StDone : StUp;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q - DwellOne;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Mealy controls so the counter halts on the very cycle it reaches a bound.
    always_comb begin
        cnt_pause = 1'b1;
        cnt_mode  = 1'b0;
        if (!aborting) begin
            case (state_q)
                StSeek: begin
                    if (cnt_value != lo_q) begin
                        cnt_pause = 1'b0;
                        cnt_mode  = (cnt_value > lo_q);
                    end
                end
                StUp: begin
                    if (cnt_value != hi_q) cnt_pause = 1'b0;
                end
                StDown: begin
                    cnt_mode = 1'b1;
                    if (cnt_value != lo_q) cnt_pause = 1'b0;
                end
                default: begin
                    cnt_pause = 1'b1;
                end
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_sweep_ctrl_8bit.sv
// Bench for sweep_ctrl_8bit: a behavioural up/down counter plus a trace model built from
// the sweep rules (seek, ramp up, dwell, ramp down, dwell) checked every cycle.
module tb_sweep_ctrl_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] dwell;
    logic [7:0] n_sweeps;
    logic [7:0] cnt_value;
    logic       cnt_pause;
    logic       cnt_mode;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] sweep_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int pos;

    typedef struct {
        int v;
        int sc;
        bit dn;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    sweep_ctrl_8bit #(
        .DWELL_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .lo        (lo),
        .hi        (hi),
        .dwell     (dwell),
        .n_sweeps  (n_sweeps),
        .cnt_value (cnt_value),
        .cnt_pause (cnt_pause),
        .cnt_mode  (cnt_mode),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    // The external counter the sequencer steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_value <= '0;
        else if (!cnt_pause) cnt_value <= cnt_mode ? cnt_value - 8'd1 : cnt_value + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v, input int sc, input bit dn);
        exp_t e;
        e.v  = v;
        e.sc = sc;
        e.dn = dn;
        q.push_back(e);
    endtask

    // Expected per-cycle trace from the cycle after start: counter value, sweep count, done.
    task automatic gen(input int l, input int h, input int dw, input int n, input int nsw);
        int v;
        v = pos;
        q.delete();
        push(v, 0, 1'b0);
        while (v != l) begin
            v += (v < l) ? 1 : -1;
            push(v, 0, 1'b0);
        end
        for (int k = 0; k < nsw; k++) begin
            for (int x = l; x <= h; x++) push(x, k, 1'b0);
            repeat (dw) push(h, k, 1'b0);
            for (int x = h; x >= l; x--) push(x, k, 1'b0);
            repeat (dw) push(l, k, 1'b0);
        end
        if (n != 0) push(l, n, 1'b1);
    endtask

    // mode 0: finite run ends normally; 1: abort on last entry; 2: stop, caller continues.
    task automatic play(input int poke, input int mode);
        exp_t last;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("cnt_value", cnt_value, q[i].v);
            chk("busy", busy, 1);
            chk("done", done, q[i].dn);
            chk("sweep_cnt", sweep_cnt, q[i].sc);
            if (i == poke) begin
                start = 1'b1;
                lo    = 8'($urandom);
                hi    = 8'($urandom);
            end
        end
        last = q[q.size()-1];
        if (mode == 1) begin
            abort = 1'b1;
            #1 chk("abort_pause", cnt_pause, 1);
            @(negedge clk);
            abort = 1'b0;
        end else if (mode == 0) begin
            @(negedge clk);
        end
        if (mode != 2) begin
            chk("tail_busy", busy, 0);
            chk("tail_done", done, 0);
            chk("tail_cnt", cnt_value, last.v);
            chk("tail_sweep_cnt", sweep_cnt, last.sc);
            pos = last.v;
        end
    endtask

    task automatic cfg(input int l, input int h, input int dw, input int n);
        lo       = 8'(l);
        hi       = 8'(h);
        dwell    = 4'(dw);
        n_sweeps = 8'(n);
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg(0, 0, 0, 0);
        pos = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sweep_cnt", sweep_cnt, 0);
        chk("rst_pause", cnt_pause, 1);
        chk("rst_mode", cnt_mode, 0);
        chk("rst_cnt", cnt_value, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single sweep with dwell from reset.
        cfg(3, 5, 2, 1);
        gen(3, 5, 2, 1, 1);
        play(-1, 0);

        // Park the counter at 10, then seek downward and run two dwell-free sweeps.
        cfg(10, 10, 0, 1);
        gen(10, 10, 0, 1, 1);
        play(-1, 0);
        cfg(4, 6, 0, 2);
        gen(4, 6, 0, 2, 2);
        play(-1, 0);

        // Continuous run aborted in the sixth sweep's ramp up at value 1.
        cfg(0, 2, 1, 0);
        gen(0, 2, 1, 0, 5);
        push(0, 5, 1'b0);
        push(1, 5, 1'b0);
        play(-1, 1);

        // Rejected start: lo > hi.
        @(negedge clk);
        cfg(9, 8, 3, 1);
        start = 1'b1;
        #1 chk("err_pause", cnt_pause, 1);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_cnt", cnt_value, pos);
        @(negedge clk);
        chk("err_clear", err, 0);

        // start and abort together in IDLE.
        cfg(9, 8, 0, 1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_err", err, 0);
        cfg(2, 3, 0, 1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy2", busy, 0);
        chk("sa_cnt", cnt_value, pos);

        // start with new bounds while busy must not disturb the run.
        cfg(2, 4, 1, 1);
        gen(2, 4, 1, 1, 1);
        play(5, 0);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            int l;
            int h;
            int d;
            int n;
            l = $urandom_range(0, 30);
            h = l + $urandom_range(0, 20);
            d = $urandom_range(0, 15);
            n = $urandom_range(1, 3);
            cfg(l, h, d, n);
            gen(l, h, d, n, n);
            play(-1, 0);
        end

        // Reset in the middle of the down ramp (value 4 on the way from 6 to 2).
        cfg(2, 6, 0, 1);
        gen(2, 6, 0, 1, 1);
        idx = ((pos > 2) ? pos - 2 : 2 - pos) + 1 + 7;
        while (q.size() > idx + 1) void'(q.pop_back());
        play(-1, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sweep_cnt", sweep_cnt, 0);
        chk("mid_rst_cnt", cnt_value, 0);
        chk("mid_rst_pause", cnt_pause, 1);
        chk("mid_rst_mode", cnt_mode, 0);
        chk("mid_rst_done", done, 0);
        #2 rst_n = 1'b1;
        pos = 0;

        // lo == hi single sweep after reset.
        cfg(1, 1, 0, 1);
        gen(1, 1, 0, 1, 1);
        play(-1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
